dut_run_ctrl: RTL and testbench

FPGA-side run sequencer for the on-board test harness of the hash core. It holds the DUT in reset, releases it, and arms the sticky uio error monitor after a settle window. It then enables the stimulus source, watches the monitor's error flag, and reports pass, fail or timeout. It sits between the board-level start button/UART trigger and the DUT, the error monitor and the stimulus generator.

---
 rtl/harness_pkg.sv | 39 +++
 rtl/phase_cnt.sv | 28 ++
 rtl/dut_run_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dut_run_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
// Shared definitions for the hash-core test harness run sequencer.
// State encodings, default phase lengths and a small sizing helper.
package harness_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    RESET  = S_RESET,
    SETTLE = S_SETTLE,
    RUN    = S_RUN,
    DRAIN  = S_DRAIN,
    DONE   = S_DONE
  } state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_DRAIN_CYCLES  = 8;
  localparam int DEF_TIMEOUT       = 1000000;
  localparam int DEF_CNT_W         = 24;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter timing the RESET, SETTLE and DRAIN phases.
// Holds at zero; load wins over decrement.
module phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dut_run_ctrl.sv
// Run sequencer: resets the DUT, arms the error monitor, runs stimulus
// and reports pass, fail or timeout with the cycle of the first error.
module dut_run_ctrl
  import harness_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             err_i,
  input  logic             stim_done_i,
  output logic             dut_rst_n_o,
  output logic             mon_nreset_o,
  output logic             stim_en_o,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] err_cycle_o
);

  localparam int PH_MAX =
    max3(RST_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES);
  localparam int PH_W =
    (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] RST_LD =
    PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SET_LD =
    PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] DRN_LD =
    PH_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           nxt;
  logic             start_q;
  logic [CNT_W-1:0] run_cnt;
  logic             ph_load;
  logic             ph_dec;
  logic             ph_zero;
  logic [PH_W-1:0]  ph_val;
  logic             fin_err;
  logic             fin_tmo;
  logic             fin_pass;
  logic             idle_like;

  assign idle_like = (state == IDLE) || (state == DONE);

  phase_cnt #(
    .W(PH_W)
  ) u_phase (
    .clk  (clk),
    .reset(reset),
    .load (ph_load),
    .val  (ph_val),
    .dec  (ph_dec),
    .zero (ph_zero)
  );

  always_comb begin
    nxt      = state;
    ph_load  = 1'b0;
    ph_val   = '0;
    ph_dec   = 1'b0;
    fin_err  = 1'b0;
    fin_tmo  = 1'b0;
    fin_pass = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_q) begin
          nxt     = RESET;
          ph_load = 1'b1;
          ph_val  = RST_LD;
        end
      end
      RESET: begin
        if (ph_zero) begin
          nxt     = SETTLE;
          ph_load = 1'b1;
          ph_val  = SET_LD;
        end else begin
          ph_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (ph_zero) nxt = RUN;
        else ph_dec = 1'b1;
      end
      RUN: begin
        if (err_i) begin
          nxt     = DONE;
          fin_err = 1'b1;
        end else if (stim_done_i) begin
          nxt     = DRAIN;
          ph_load = 1'b1;
          ph_val  = DRN_LD;
        end else if (run_cnt == LAST) begin
          nxt     = DONE;
          fin_tmo = 1'b1;
        end
      end
      DRAIN: begin
        if (err_i) begin
          nxt     = DONE;
          fin_err = 1'b1;
        end else if (ph_zero) begin
          nxt      = DONE;
          fin_pass = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // start is captured a cycle early so RESET begins one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      run_cnt      <= '0;
      dut_rst_n_o  <= 1'b0;
      mon_nreset_o <= 1'b0;
      stim_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      timeout_o    <= 1'b0;
      err_cycle_o  <= '0;
    end else begin
      state   <= nxt;
      start_q <= start_i && idle_like;

      dut_rst_n_o  <= (nxt == SETTLE) || (nxt == RUN) ||
                      (nxt == DRAIN) || (nxt == DONE);
      mon_nreset_o <= (nxt == RUN) || (nxt == DRAIN) ||
                      (nxt == DONE);
      stim_en_o    <= (nxt == RUN);
      busy_o       <= (nxt == RESET) || (nxt == SETTLE) ||
                      (nxt == RUN) || (nxt == DRAIN);

      if ((state != RUN) && (nxt == RUN)) begin
        run_cnt <= '0;
      end else if ((state == RUN) || (state == DRAIN)) begin
        run_cnt <= run_cnt + 1'b1;
      end

      if ((state == IDLE) || (idle_like && start_q)) begin
        pass_o      <= 1'b0;
        fail_o      <= 1'b0;
        timeout_o   <= 1'b0;
        err_cycle_o <= '0;
      end
      if (fin_err) begin
        fail_o      <= 1'b1;
        err_cycle_o <= run_cnt;
      end
      if (fin_tmo) begin
        fail_o    <= 1'b1;
        timeout_o <= 1'b1;
      end
      if (fin_pass) begin
        pass_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dut_run_ctrl.sv
// Scoreboard bench for dut_run_ctrl with short phase parameters.
// Results are queued at stimulus time and checked when a run ends.
module tb_dut_run_ctrl;

  localparam int CW = 24;

  typedef struct {
    logic          pass;
    logic          fail;
    logic          tmo;
    logic [CW-1:0] ec;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic          err_i = 1'b0;
  logic          stim_done_i = 1'b0;
  logic          dut_rst_n_o;
  logic          mon_nreset_o;
  logic          stim_en_o;
  logic          busy_o;
  logic          pass_o;
  logic          fail_o;
  logic          timeout_o;
  logic [CW-1:0] err_cycle_o;

  int   tests = 0;
  int   fails = 0;
  res_t exp_q[$];
  logic busy_q = 1'b0;

  always #5 clk = ~clk;

  dut_run_ctrl #(
    .RST_CYCLES   (4),
    .SETTLE_CYCLES(2),
    .DRAIN_CYCLES (3),
    .TIMEOUT      (100),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .err_i       (err_i),
    .stim_done_i (stim_done_i),
    .dut_rst_n_o (dut_rst_n_o),
    .mon_nreset_o(mon_nreset_o),
    .stim_en_o   (stim_en_o),
    .busy_o      (busy_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .err_cycle_o (err_cycle_o)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves the bench at the negedge just after edge 0
  task automatic kick();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic push(
    input logic          p,
    input logic          f,
    input logic          t,
    input logic [CW-1:0] e
  );
    res_t r;
    r.pass = p;
    r.fail = f;
    r.tmo  = t;
    r.ec   = e;
    exp_q.push_back(r);
  endtask

  function automatic logic [6:0] outs();
    return {dut_rst_n_o, mon_nreset_o, stim_en_o,
            busy_o, pass_o, fail_o, timeout_o};
  endfunction

  always @(negedge clk) begin
    if (busy_q && !busy_o && (pass_o || fail_o)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got p%0b f%0b t%0b",
                 pass_o, fail_o, timeout_o);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if ({pass_o, fail_o, timeout_o, err_cycle_o} !==
            {e.pass, e.fail, e.tmo, e.ec}) begin
          fails++;
          $display(
            "FAIL result: got p%0b f%0b t%0b ec%0d expected p%0b f%0b t%0b ec%0d",
            pass_o, fail_o, timeout_o, err_cycle_o,
            e.pass, e.fail, e.tmo, e.ec);
        end
      end
    end
    busy_q <= busy_o;
  end

  initial begin
    step(1);
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_ec", 32'(err_cycle_o), 32'h0);
    reset = 1'b0;
    step(2);
    check("idle_outs", 32'(outs()), 32'h0);

    // clean run
    kick();
    check("e0_not_busy", 32'(busy_o), 32'h0);
    step(1);
    check("e1_rst_low", 32'(outs()), 32'b0001000);
    step(3);
    check("e4_rst_low", 32'(dut_rst_n_o), 32'h0);
    step(1);
    check("e5_release", 32'(outs()), 32'b1001000);
    step(1);
    check("e6_mon_off", 32'(mon_nreset_o), 32'h0);
    step(1);
    check("e7_run", 32'(outs()), 32'b1111000);
    step(20);
    stim_done_i = 1'b1;
    push(1'b1, 1'b0, 1'b0, '0);
    step(1);
    stim_done_i = 1'b0;
    check("drain_outs", 32'(outs()), 32'b1101000);
    step(2);
    check("drain_no_pass", 32'(pass_o), 32'h0);
    step(1);
    check("done_outs", 32'(outs()), 32'b1100100);

    // error in RUN at counter 37
    step(2);
    kick();
    step(44);
    err_i = 1'b1;
    push(1'b0, 1'b1, 1'b0, 24'd37);
    step(1);
    err_i = 1'b0;
    check("err_stim_off", 32'(stim_en_o), 32'h0);

    // restart from DONE, then err+stim_done at 10
    step(2);
    kick();
    check("done_held", 32'(fail_o), 32'h1);
    step(1);
    check("restart_outs", 32'(outs()), 32'b0001000);
    check("restart_ec", 32'(err_cycle_o), 32'h0);
    step(16);
    err_i = 1'b1;
    stim_done_i = 1'b1;
    push(1'b0, 1'b1, 1'b0, 24'd10);
    step(1);
    err_i = 1'b0;
    stim_done_i = 1'b0;
    check("prio_no_drain", 32'(busy_o), 32'h0);

    // error coincident with timeout
    step(2);
    kick();
    step(106);
    err_i = 1'b1;
    push(1'b0, 1'b1, 1'b0, 24'd99);
    step(1);
    err_i = 1'b0;

    // pure timeout after 100 RUN cycles
    step(2);
    kick();
    step(106);
    check("pre_timeout", 32'({busy_o, timeout_o}), 32'b10);
    push(1'b0, 1'b1, 1'b1, '0);
    step(1);
    check("timeout_outs", 32'(outs()), 32'b1100011);

    // ignored events and async reset mid-run
    step(2);
    kick();
    step(5);
    err_i = 1'b1;
    step(2);
    err_i = 1'b0;
    check("settle_err_ign", 32'(outs()), 32'b1111000);
    step(2);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(1);
    check("start_run_ign", 32'(outs()), 32'b1111000);
    step(1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs()), 32'h0);
    check("async_rst_ec", 32'(err_cycle_o), 32'h0);
    step(1);
    reset = 1'b0;
    step(1);
    kick();
    step(1);
    check("rerun_rst_low", 32'(outs()), 32'b0001000);
    step(6);
    check("rerun_run", 32'(outs()), 32'b1111000);
    step(3);
    stim_done_i = 1'b1;
    push(1'b1, 1'b0, 1'b0, '0);
    step(1);
    stim_done_i = 1'b0;
    step(5);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
